// File: rtl/mux_pkg.sv
// Shared select encodings for the 4-to-1 mux cells.
package mux_pkg;
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'b00;
  localparam sel_t SEL_I1 = 2'b01;
  localparam sel_t SEL_I2 = 2'b10;
  localparam sel_t SEL_I3 = 2'b11;
endpackage

// File: rtl/mux4_comb.sv
// Purely combinational 4-to-1 selector; any unresolved select yields zero.
module mux4_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  sel_t             sel,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = '0;
    case (sel)
      SEL_I0:  nxt = i0;
      SEL_I1:  nxt = i1;
      SEL_I2:  nxt = i2;
      SEL_I3:  nxt = i3;
      default: nxt = '0;
    endcase
  end

endmodule

// File: rtl/mux4_1_alwys.sv
// Registered 4-to-1 multiplexer: combinational select stage followed by a
// single output register with synchronous active-high reset.
module mux4_1_alwys
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out
);

  sel_t             sel;
  logic [WIDTH-1:0] nxt;

  assign sel = {s1, s0};

  mux4_comb #(.WIDTH(WIDTH)) u_comb (
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .sel (sel),
    .nxt (nxt)
  );

  // Reset takes priority; the first edge with rst low loads the selection.
  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= nxt;
  end

endmodule

// File: tb/tb_mux4_1_alwys.sv
// Bench for mux4_1_alwys: one WIDTH=1 and one WIDTH=8 instance share stimulus.
module tb_mux4_1_alwys;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
  logic       s0 = 1'b0, s1 = 1'b0;
  logic [0:0] out1;
  logic [7:0] out8;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  mux4_1_alwys #(.WIDTH(1)) dut1 (
    .clk (clk), .rst (rst),
    .i0 (a0[0]), .i1 (a1[0]), .i2 (a2[0]), .i3 (a3[0]),
    .s0 (s0), .s1 (s1), .out (out1)
  );

  mux4_1_alwys #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst),
    .i0 (a0), .i1 (a1), .i2 (a2), .i3 (a3),
    .s0 (s0), .s1 (s1), .out (out8)
  );

  // Reference: the inputs form an array indexed by the select number.
  function automatic logic [7:0] model(input logic r, input logic [1:0] sel,
                                       input logic [7:0] v0, input logic [7:0] v1,
                                       input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] ins [4];
    ins[0] = v0; ins[1] = v1; ins[2] = v2; ins[3] = v3;
    return r ? 8'h00 : ins[sel];
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] sel, input logic [7:0] v0,
                       input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    rst = r; s1 = sel[1]; s0 = sel[0];
    a0 = v0; a1 = v1; a2 = v2; a3 = v3;
    exp_q.push_back(model(r, sel, v0, v1, v2, v3));
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    drive(1'b1, 2'b10, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick();
    void'(exp_q.pop_front());
    drive(1'b1, 2'b10, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (out8 !== exp || out1 !== exp[0]) begin
      errors++;
      $display("FAIL reset: out1=%b out8=%h expected %b/%h", out1, out8, exp[0], exp);
    end
    drive(1'b0, 2'b10, 8'h00, 8'h00, 8'h5B, 8'h00);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (out8 !== exp || out1 !== exp[0]) begin
      errors++;
      $display("FAIL reset_release: out1=%b out8=%h expected %b/%h", out1, out8, exp[0], exp);
    end
  endtask

  task automatic test_sweep_w1();
    // {sel, i0, i1, i2, i3} per row
    logic [5:0] tbl [8];
    logic [0:0] exp;
    tbl[0] = {2'b00, 4'b0000}; tbl[1] = {2'b00, 4'b1000};
    tbl[2] = {2'b01, 4'b1000}; tbl[3] = {2'b01, 4'b0100};
    tbl[4] = {2'b10, 4'b0000}; tbl[5] = {2'b10, 4'b0010};
    tbl[6] = {2'b11, 4'b0000}; tbl[7] = {2'b11, 4'b0001};
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, tbl[k][5:4], {7'd0, tbl[k][3]}, {7'd0, tbl[k][2]},
            {7'd0, tbl[k][1]}, {7'd0, tbl[k][0]});
      tick();
      exp = exp_q.pop_front() & 8'h01;
      checks++;
      if (out1 !== exp) begin
        errors++;
        $display("FAIL sweep_w1[%0d]: out1=%b expected %b", k, out1, exp);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] exp;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'hFF);
    tick();
    void'(exp_q.pop_front());
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
    #1;
    checks++;
    if (out8 !== 8'h00 || out1 !== 1'b0) begin
      errors++;
      $display("FAIL latency_before: out1=%b out8=%h expected 0/00", out1, out8);
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (out8 !== exp || out1 !== exp[0]) begin
      errors++;
      $display("FAIL latency_after: out1=%b out8=%h expected %b/%h", out1, out8, exp[0], exp);
    end
  endtask

  task automatic test_isolation();
    logic [7:0] exp;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 2'b10, (k % 2) ? 8'hFF : 8'h00, (k % 2) ? 8'h00 : 8'hFF,
            8'hFF, (k % 2) ? 8'hFF : 8'h00);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (out8 !== exp || out1 !== 1'b1) begin
        errors++;
        $display("FAIL isolation[%0d]: out1=%b out8=%h expected 1/%h", k, out1, out8, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp;
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
    tick();
    void'(exp_q.pop_front());
    drive(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (out8 !== exp || out1 !== exp[0]) begin
      errors++;
      $display("FAIL reset_mid: out1=%b out8=%h expected %b/%h", out1, out8, exp[0], exp);
    end
    drive(1'b0, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (out8 !== exp || out1 !== exp[0]) begin
      errors++;
      $display("FAIL reset_mid_release: out1=%b out8=%h expected %b/%h", out1, out8, exp[0], exp);
    end
  endtask

  task automatic test_sweep_w8();
    logic [7:0] exp;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'(k), 8'hA5, 8'h3C, 8'hFF, 8'h00);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (out8 !== exp) begin
        errors++;
        $display("FAIL sweep_w8[%0d]: out8=%h expected %h", k, out8, exp);
      end
    end
    // Unknown select LSB: both candidate inputs are zero, so zero is expected
    // however the unknown resolves.
    a0 = 8'h00; a1 = 8'h00; a2 = 8'hFF; a3 = 8'hC3;
    s1 = 1'b0; s0 = 1'bx;
    tick();
    checks++;
    if (out8 !== 8'h00) begin
      errors++;
      $display("FAIL sel_x: out8=%h expected 00", out8);
    end
    s0 = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int k = 0; k < 200; k++) begin
      drive(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (out8 !== exp || out1 !== exp[0]) begin
        errors++;
        $display("FAIL random[%0d]: out1=%b out8=%h expected %b/%h", k, out1, out8, exp[0], exp);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_sweep_w1();
    test_latency();
    test_isolation();
    test_reset_midstream();
    test_sweep_w8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
